// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator. Free-running horizontal/vertical counters publish
// the current coordinate to an upstream pixel source. Sync and data-enable
// flags are delayed through a PIPE_DEPTH-stage line so they leave the block
// together with the pixel the source returns for that coordinate.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   en           pixel-rate enable; all state advances only on enabled edges
//   in_pixel     source pixel for the coordinate issued PIPE_DEPTH-1 beats ago
//   hcount       current horizontal coordinate
//   vcount       current vertical coordinate
//   active       current coordinate lies in the visible area (combinational)
//   hsync/vsync  pipeline-aligned syncs, asserted level set by *_POL
//   de           pipeline-aligned data enable
//   out_pixel    in_pixel while de, else 0
//   frame_start  one-clk pulse when coordinate (0,0) reaches the output
//   line_start   one-clk pulse when any coordinate (0,v) reaches the output
//
// Handshake: there is no valid/ready pair here. The source must present the
// pixel for coordinate (h,v) on in_pixel exactly PIPE_DEPTH-1 enabled beats
// after (h,v) appeared on hcount/vcount; en gates every beat for both sides.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 11,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 32,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIXEL_W    = 24,
  parameter int PIPE_DEPTH = 2,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PIXEL_W-1:0] in_pixel,
  output logic [HW-1:0]      hcount,
  output logic [VW-1:0]      vcount,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic               frame_start,
  output logic               line_start
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [31:0] HA_U  = 32'(H_ACTIVE);
  localparam logic [31:0] HS_LO = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_HI = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VA_U  = 32'(V_ACTIVE);
  localparam logic [31:0] VS_LO = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_HI = 32'(V_ACTIVE + V_FP + V_SYNC);

  // Flag positions inside one delay-line stage. Every flag is stored as
  // "asserted = 1" so an all-zero stage is the blank, inactive value.
  localparam int F_HS = 0;
  localparam int F_VS = 1;
  localparam int F_DE = 2;
  localparam int F_LS = 3;
  localparam int F_FS = 4;

  logic [31:0] h_ext;
  logic [31:0] v_ext;
  logic [4:0]  cur_flags;
  logic [4:0]  pipe [PIPE_DEPTH];
  logic [4:0]  out_q;
  logic        pre_de;   // active flag of the coordinate about to be output
  logic        fresh;    // last clk edge was an enabled one

  assign h_ext = 32'(hcount);
  assign v_ext = 32'(vcount);

  assign active = (h_ext < HA_U) && (v_ext < VA_U);

  assign cur_flags[F_HS] = (h_ext >= HS_LO) && (h_ext < HS_HI);
  assign cur_flags[F_VS] = (v_ext >= VS_LO) && (v_ext < VS_HI);
  assign cur_flags[F_DE] = active;
  assign cur_flags[F_LS] = (hcount == '0);
  assign cur_flags[F_FS] = (hcount == '0) && (vcount == '0);

  // Raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (en) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        if (vcount == V_LAST) vcount <= '0;
        else                  vcount <= vcount + VW'(1);
      end else begin
        hcount <= hcount + HW'(1);
      end
    end
  end

  // Flag delay line; the last stage is the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= cur_flags;
      for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_q = pipe[PIPE_DEPTH-1];

  // With a single stage the output loads straight from the counters, so the
  // source has to answer combinationally.
  generate
    if (PIPE_DEPTH == 1) begin : g_pre_direct
      assign pre_de = cur_flags[F_DE];
    end else begin : g_pre_pipe
      assign pre_de = pipe[PIPE_DEPTH-2][F_DE];
    end
  endgenerate

  // Pixel capture and the enabled-edge marker used to make the start
  // pulses exactly one clk wide even when en stays low afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pixel <= '0;
      fresh     <= 1'b0;
    end else begin
      fresh <= en;
      if (en) out_pixel <= pre_de ? in_pixel : '0;
    end
  end

  // XNOR with the polarity maps "asserted" onto the configured level; the
  // reset stage (flag 0) therefore drives the inactive level.
  assign hsync       = out_q[F_HS] ~^ HSYNC_POL;
  assign vsync       = out_q[F_VS] ~^ VSYNC_POL;
  assign de          = out_q[F_DE];
  assign line_start  = out_q[F_LS] & fresh;
  assign frame_start = out_q[F_FS] & fresh;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Four instances with different geometry,
// polarity and pipeline depth run side by side from one clock and reset;
// each has its own enable and pixel source. Expected outputs come from a
// beat-count model: after k enabled beats the counters show raster index k
// and the outputs show raster index k-PIPE_DEPTH.
module tb_vga_timing_gen;

  // Instance 0: default horizontal timing, short frame, depth 2, active-low
  // Instance 1: small, active-high syncs, depth 1
  // Instance 2: 8/1/2/1 x 4/1/1/1, depth 4
  // Instance 3: 8/1/2/1 x 4/1/1/1, depth 8
  localparam int P_HA[4] = '{640, 16, 8, 8};
  localparam int P_HF[4] = '{16,  2,  1, 1};
  localparam int P_HS[4] = '{96,  3,  2, 2};
  localparam int P_HT[4] = '{800, 23, 12, 12};
  localparam int P_VA[4] = '{10,  6,  4, 4};
  localparam int P_VF[4] = '{2,   1,  1, 1};
  localparam int P_VS[4] = '{2,   2,  1, 1};
  localparam int P_VT[4] = '{17,  10, 7, 7};
  localparam bit P_HP[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit P_VP[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam int P_D[4]  = '{2,   1,  4, 8};

  logic        clk;
  logic        rst;
  logic [3:0]  en_v;
  logic [23:0] pix [4];

  logic [9:0]  hc0; logic [4:0] vc0;
  logic [4:0]  hc1; logic [3:0] vc1;
  logic [3:0]  hc2; logic [2:0] vc2;
  logic [3:0]  hc3; logic [2:0] vc3;
  logic [3:0]  act, hs, vs, de, fs, ls;
  logic [23:0] px0, px1, px2, px3;
  logic [53:0] obs [4];

  longint k [4];
  bit     last_en [4];
  int     cyc;
  int     n_pass;
  int     n_total;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  vga_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                   .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
                   .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIXEL_W(24), .PIPE_DEPTH(2))
  u_a (.clk(clk), .rst(rst), .en(en_v[0]), .in_pixel(pix[0]), .hcount(hc0), .vcount(vc0),
       .active(act[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .out_pixel(px0),
       .frame_start(fs[0]), .line_start(ls[0]));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIXEL_W(24), .PIPE_DEPTH(1))
  u_b (.clk(clk), .rst(rst), .en(en_v[1]), .in_pixel(pix[1]), .hcount(hc1), .vcount(vc1),
       .active(act[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .out_pixel(px1),
       .frame_start(fs[1]), .line_start(ls[1]));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIXEL_W(24), .PIPE_DEPTH(4))
  u_c (.clk(clk), .rst(rst), .en(en_v[2]), .in_pixel(pix[2]), .hcount(hc2), .vcount(vc2),
       .active(act[2]), .hsync(hs[2]), .vsync(vs[2]), .de(de[2]), .out_pixel(px2),
       .frame_start(fs[2]), .line_start(ls[2]));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIXEL_W(24), .PIPE_DEPTH(8))
  u_d (.clk(clk), .rst(rst), .en(en_v[3]), .in_pixel(pix[3]), .hcount(hc3), .vcount(vc3),
       .active(act[3]), .hsync(hs[3]), .vsync(vs[3]), .de(de[3]), .out_pixel(px3),
       .frame_start(fs[3]), .line_start(ls[3]));

  assign obs[0] = {12'(hc0), 12'(vc0), act[0], hs[0], vs[0], de[0], ls[0], fs[0], px0};
  assign obs[1] = {12'(hc1), 12'(vc1), act[1], hs[1], vs[1], de[1], ls[1], fs[1], px1};
  assign obs[2] = {12'(hc2), 12'(vc2), act[2], hs[2], vs[2], de[2], ls[2], fs[2], px2};
  assign obs[3] = {12'(hc3), 12'(vc3), act[3], hs[3], vs[3], de[3], ls[3], fs[3], px3};

  // ---------------- reference model ----------------
  function automatic logic [23:0] pixel_of(int h, int v);
    return {8'(v), 8'(h), 8'hA5};
  endfunction

  // Expected {hcount, vcount, active, hsync, vsync, de, line_start,
  // frame_start, out_pixel} for instance i after k[i] enabled beats.
  function automatic logic [53:0] model(int i);
    longint kk, m;
    int h, v, ho, vo;
    logic a, hsx, vsx, dex, lsx, fsx;
    logic [23:0] p;
    kk  = k[i];
    h   = int'(kk % P_HT[i]);
    v   = int'((kk / P_HT[i]) % P_VT[i]);
    a   = (h < P_HA[i]) && (v < P_VA[i]);
    hsx = !P_HP[i];
    vsx = !P_VP[i];
    dex = 1'b0; lsx = 1'b0; fsx = 1'b0; p = '0;
    if (kk >= P_D[i]) begin
      m   = kk - P_D[i];
      ho  = int'(m % P_HT[i]);
      vo  = int'((m / P_HT[i]) % P_VT[i]);
      hsx = (ho >= P_HA[i] + P_HF[i] && ho < P_HA[i] + P_HF[i] + P_HS[i]) ? P_HP[i] : !P_HP[i];
      vsx = (vo >= P_VA[i] + P_VF[i] && vo < P_VA[i] + P_VF[i] + P_VS[i]) ? P_VP[i] : !P_VP[i];
      dex = (ho < P_HA[i]) && (vo < P_VA[i]);
      p   = dex ? pixel_of(ho, vo) : 24'h0;
      lsx = last_en[i] && (ho == 0);
      fsx = lsx && (vo == 0);
    end
    return {12'(h), 12'(v), a, hsx, vsx, dex, lsx, fsx, p};
  endfunction

  // Upstream source: answers with PIPE_DEPTH-1 beats of latency; blanked
  // coordinates get random junk that must never reach out_pixel.
  function automatic logic [23:0] src(int i);
    longint kk;
    int h, v;
    kk = k[i] - longint'(P_D[i] - 1);
    if (kk < 0) return 24'($urandom);
    h = int'(kk % P_HT[i]);
    v = int'((kk / P_HT[i]) % P_VT[i]);
    if (h < P_HA[i] && v < P_VA[i]) return pixel_of(h, v);
    return 24'($urandom);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [3:0] e);
    en_v = e;
    for (int i = 0; i < 4; i++) pix[i] = src(i);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst && e[i]) k[i]++;
      last_en[i] = !rst && e[i];
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin k[i] = 0; last_en[i] = 1'b0; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin k[i] = 0; last_en[i] = 1'b0; end
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (obs[i] !== model(i)) $display("FAIL reset_hold inst%0d: got %h exp %h", i, obs[i], model(i));
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (obs[i] !== model(i)) $display("FAIL reset_release inst%0d: got %h exp %h", i, obs[i], model(i));
      else n_pass++;
    end
  endtask

  task automatic test_continuous();
    int  h0_cyc = 0, hs_fall = 0, de_rise = 0, vs_fall = 0, fs_prev = -1, frames = 0;
    bit  hs_p = 1'b1, de_p = 1'b0, vs_p = 1'b1;
    apply_reset();
    for (int n = 0; n < 13600 + 20; n++) begin
      tick(4'hF);
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (obs[i] !== model(i)) $display("FAIL cont inst%0d cyc %0d: got %h exp %h", i, cyc, obs[i], model(i));
        else n_pass++;
      end
      if (hc0 == 10'd0) h0_cyc = cyc;
      if (hs_p && !hs[0]) begin
        n_total++;
        if (cyc - h0_cyc !== 658) $display("FAIL hsync_offset cyc %0d: got %0d exp 658", cyc, cyc - h0_cyc);
        else n_pass++;
        hs_fall = cyc;
      end
      if (!hs_p && hs[0]) begin
        n_total++;
        if (cyc - hs_fall !== 96) $display("FAIL hsync_width cyc %0d: got %0d exp 96", cyc, cyc - hs_fall);
        else n_pass++;
      end
      if (!de_p && de[0]) de_rise = cyc;
      if (de_p && !de[0]) begin
        n_total++;
        if (cyc - de_rise !== 640) $display("FAIL de_run cyc %0d: got %0d exp 640", cyc, cyc - de_rise);
        else n_pass++;
      end
      if (vs_p && !vs[0]) vs_fall = cyc;
      if (!vs_p && vs[0]) begin
        n_total++;
        if (cyc - vs_fall !== 1600) $display("FAIL vsync_width cyc %0d: got %0d exp 1600", cyc, cyc - vs_fall);
        else n_pass++;
      end
      if (fs[0]) begin
        if (fs_prev >= 0) begin
          n_total++;
          if (cyc - fs_prev !== 13600) $display("FAIL frame_period cyc %0d: got %0d exp 13600", cyc, cyc - fs_prev);
          else n_pass++;
        end
        fs_prev = cyc;
        frames++;
      end
      hs_p = hs[0]; de_p = de[0]; vs_p = vs[0];
    end
    n_total++;
    if (frames !== 2) $display("FAIL frame_count: got %0d exp 2", frames);
    else n_pass++;
  endtask

  task automatic test_en_toggle();
    int fs_prev = -1, frames = 0;
    apply_reset();
    for (int n = 0; n < 2 * 13600 + 20; n++) begin
      tick((n % 2 == 0) ? 4'hF : 4'h0);
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (obs[i] !== model(i)) $display("FAIL toggle inst%0d cyc %0d: got %h exp %h", i, cyc, obs[i], model(i));
        else n_pass++;
      end
      if (fs[0]) begin
        if (fs_prev >= 0) begin
          n_total++;
          if (cyc - fs_prev !== 27200) $display("FAIL toggle_period cyc %0d: got %0d exp 27200", cyc, cyc - fs_prev);
          else n_pass++;
        end
        fs_prev = cyc;
        frames++;
      end
    end
    n_total++;
    if (frames !== 2) $display("FAIL toggle_frames: got %0d exp 2", frames);
    else n_pass++;
  endtask

  task automatic test_random_en();
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      tick(4'($urandom));
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (obs[i] !== model(i)) $display("FAIL rand_en inst%0d cyc %0d: got %h exp %h", i, cyc, obs[i], model(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_reset();
    longint target;
    int w;
    apply_reset();
    // Stop inside the horizontal sync window of a line close to vsync.
    target = 11 * 800 + 700;
    for (int n = 0; n < 20000 && k[0] < target; n++) tick(4'b0001 | 4'($urandom));
    n_total++;
    if (k[0] !== target) $display("FAIL mid_reach: got %0d exp %0d", k[0], target);
    else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin k[i] = 0; last_en[i] = 1'b0; end
    #1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (obs[i] !== model(i)) $display("FAIL mid_async inst%0d: got %h exp %h", i, obs[i], model(i));
      else n_pass++;
    end
    for (int n = 0; n < 3; n++) begin
      tick(4'hF);
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (obs[i] !== model(i)) $display("FAIL mid_held inst%0d: got %h exp %h", i, obs[i], model(i));
        else n_pass++;
      end
    end
    rst = 1'b0;
    w = 0;
    do begin
      tick(4'hF);
      w++;
    end while (!fs[0] && w < 20);
    n_total++;
    if (w !== 2 || fs[0] !== 1'b1) $display("FAIL mid_fs_latency: got %0d beats fs=%b exp 2 beats fs=1", w, fs[0]);
    else n_pass++;
    for (int n = 0; n < 1000; n++) begin
      tick(4'($urandom));
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (obs[i] !== model(i)) $display("FAIL mid_after inst%0d cyc %0d: got %h exp %h", i, cyc, obs[i], model(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_small_wrap();
    int eh = 0, ev = 0, hmax = 0, vmax = 0;
    apply_reset();
    for (int n = 0; n < 2 * 84 + 4; n++) begin
      n_total++;
      if (hc2 !== 4'(eh) || vc2 !== 3'(ev))
        $display("FAIL wrap_seq step %0d: got (%0d,%0d) exp (%0d,%0d)", n, hc2, vc2, eh, ev);
      else n_pass++;
      if (int'(hc2) > hmax) hmax = int'(hc2);
      if (int'(vc2) > vmax) vmax = int'(vc2);
      tick(4'hF);
      if (eh == 11) begin eh = 0; ev = (ev == 6) ? 0 : ev + 1; end
      else eh++;
    end
    n_total++;
    if (hmax !== 11 || vmax !== 6) $display("FAIL wrap_max: got (%0d,%0d) exp (11,6)", hmax, vmax);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst     = 1'b1;
    en_v    = 4'h0;
    for (int i = 0; i < 4; i++) begin pix[i] = '0; k[i] = 0; last_en[i] = 1'b0; end
    cyc     = 0;
    n_pass  = 0;
    n_total = 0;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_en_toggle();
    test_random_en();
    test_mid_reset();
    test_small_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
